// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M iterative divider.
package div_unit_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } state_t;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up in a final cycle, single-cycle divide-by-zero path.

// One restoring step: shift {rem, quo} left, trial-subtract, keep on non-negative.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);
   logic [WIDTH:0] w_sh;
   logic [WIDTH:0] w_diff;

   // Stored remainder is always < divisor, so only the shifted trial value
   // needs the extra bit to carry the subtract sign.
   assign w_sh   = {i_rem, i_quo[WIDTH-1]};
   assign w_diff = w_sh - {1'b0, i_dvs};
   assign o_rem  = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign o_quo  = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] result,
   output logic             ready,
   output logic             busy
);
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_is_rem;
   logic             r_qneg;
   logic             r_rneg;
   logic [WIDTH-1:0] r_result;
   logic             r_ready;

   logic             w_signed;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   assign w_signed  = ~op[0];
   assign w_a_neg   = w_signed & dividend[WIDTH-1];
   assign w_b_neg   = w_signed & divisor[WIDTH-1];
   assign w_a_mag   = w_a_neg ? (~dividend + 1'b1) : dividend;
   assign w_b_mag   = w_b_neg ? (~divisor + 1'b1) : divisor;
   assign w_quo_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_fix = r_rneg ? (~r_rem + 1'b1) : r_rem;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_dvs),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_is_rem <= 1'b0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_is_rem <= op[1];
                  if (divisor == '0) begin
                     // Divide-by-zero answers immediately without iterating.
                     r_result <= op[1] ? dividend : '1;
                     r_ready  <= 1'b1;
                  end else begin
                     r_quo   <= w_a_mag;
                     r_dvs   <= w_b_mag;
                     r_rem   <= '0;
                     r_qneg  <= w_a_neg ^ w_b_neg;
                     r_rneg  <= w_a_neg;
                     r_cnt   <= CNT_W'(WIDTH);
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) r_state <= FIX;
            end
            FIX: begin
               r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
               r_ready  <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign result = r_result;
   assign ready  = r_ready;
   assign busy   = (r_state != IDLE);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus handshake/reset sequences,
// expected results queued at issue and compared when ready pulses.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] result;
   logic         ready;
   logic         busy;

   div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .result   (result),
      .ready    (ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t         tbl[14];
   logic [W-1:0] sb[$];
   int           n_chk = 0;
   int           n_pass = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Waits (bounded) for ready; k0 = negedges already elapsed since start was driven.
   task automatic wait_done(input string nm, input int k0, input int exp_k);
      int k;
      logic [W-1:0] ex;
      k = k0;
      while (!ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " latency"}, W'(k), W'(exp_k));
      if (sb.size() == 0) begin
         n_chk++;
         $display("FAIL %s: scoreboard empty, got %h expected an entry", nm, result);
      end else begin
         ex = sb.pop_front();
         chk({nm, " result"}, result, ex);
      end
      chk({nm, " idle_at_ready"}, W'(busy), '0);
   endtask

   // Drive a start at the current negedge; returns on the negedge where ready is seen.
   task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e);
      op = o; dividend = a; divisor = b; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); dividend = $urandom; divisor = $urandom;
      if (b != '0) begin
         chk({nm, " busy"}, W'(busy), W'(1));
         chk({nm, " no_early_ready"}, W'(ready), '0);
      end
      wait_done(nm, 1, (b == '0) ? 1 : W + 2);
   endtask

   initial begin
      bit seen;
      tbl[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14};
      tbl[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2};
      tbl[2]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
      tbl[3]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
      tbl[4]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
      tbl[5]  = '{OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1};
      tbl[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF};
      tbl[7]  = '{OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
      tbl[8]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
      tbl[9]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0};
      tbl[10] = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14};
      tbl[11] = '{OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE};
      tbl[12] = '{OP_DIVU, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF};
      tbl[13] = '{OP_REMU, 32'hFFFFFFFF,   32'h10,         32'hF};

      repeat (2) @(negedge clk);
      chk("reset result", result, '0);
      chk("reset ready", W'(ready), '0);
      chk("reset busy", W'(busy), '0);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
         @(negedge clk);
         chk($sformatf("vec%0d pulse", i), W'(ready), '0);
      end

      // Start while busy must be ignored.
      op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      sb.push_back(32'd14);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ignored busy", W'(busy), W'(1));
      wait_done("ignored", 11, W + 2);

      // Back-to-back: start during the ready cycle is accepted.
      do_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14);
      do_op("b2b_second", OP_DIVU, 32'd9, 32'd3, 32'd3);
      @(negedge clk);

      // Asynchronous reset mid-operation abandons it.
      op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk("midreset busy", W'(busy), '0);
      chk("midreset ready", W'(ready), '0);
      chk("midreset result", result, '0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      chk("no ready after reset", W'(seen), '0);
      do_op("post_reset", OP_DIVU, 32'd9, 32'd3, 32'd3);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits between the register file read ports and the writeback mux.
- Operands come from the latched rs1/rs2 values; the result goes to the register file write-data path.
- The multicycle controller issues `start` and waits on `ready`.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WIDTH  rs1 value.
- divisor  input  WIDTH  rs2 value.
- result  output  WIDTH  quotient or remainder; held until the next accepted start.
- ready  output  1  one-cycle pulse when result is valid.
- busy  output  1  high while an operation is in progress (state != IDLE).

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; result=0, ready=0, busy=0.
  - Counter and internal quotient/remainder registers cleared.
  - Reset mid-operation abandons the operation; no ready pulse follows.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Signed ops (op[0]=0): operands converted to magnitudes; record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Unsigned ops: q_neg = r_neg = 0.
  - Counter loaded with WIDTH; partial remainder cleared; state=CALC.
- Divide-by-zero fast path (divisor==0 at E0):
  - No CALC. result = all-ones for DIV/DIVU; result = raw dividend for REM/REMU.
  - ready=1 after E0; state stays IDLE.
- CALC, each edge:
  - Shift {rem, quo} left by 1, shifting in the quotient MSB.
  - Trial subtract of the divisor magnitude from the (WIDTH+1)-bit partial remainder.
  - If non-negative: keep the difference and set quotient bit 0 to 1.
  - Decrement the counter. When the counter reaches 0 after this edge, state=FIX.
  - Exactly WIDTH CALC edges (E1..E32 for WIDTH=32).
- FIX, edge E(WIDTH+1):
  - result = q_neg ? -quo : quo for DIV/DIVU.
  - result = r_neg ? -rem : rem for REM/REMU.
  - ready=1; state=IDLE.
- ready timing:
  - ready is high for exactly the one cycle following the FIX edge (or E0 on the fast path).
  - It is cleared on the next edge regardless of start.
- Latency: WIDTH+1 edges start→ready for a normal operation; 1 edge for divide-by-zero.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - Handled by the normal path with no special case.
  - Magnitude 2^31 fits unsigned, so DIV yields 0x80000000 and REM yields 0.
- start while busy=1: ignored; operands not sampled; no effect on the running operation.
- start in the same cycle that ready=1 (state IDLE): accepted; ready still drops on that edge.
- Inputs dividend/divisor/op may change freely after E0.
- result is stable from the ready cycle until the FIX or fast-path edge of the next accepted operation.
- All arithmetic is modulo 2^WIDTH. Negation is two's complement. The partial remainder is WIDTH+1 bits to hold the trial-subtract sign.

Decomposition:
- Shared package holds:
  - op encodings OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11;
  - state encodings IDLE/CALC/FIX.
- Opcode decode from funct3 lives in the control unit, not here.
- No sub-module required. The single iteration step (shift, trial subtract, select) may be factored as the combinational sub-module div_step if the team prefers, but it stays in this file.

Test Plan:
- DIVU 100/7: start at E0 → busy=1 E0..E32, ready=1 for one cycle after E33, result=14; REMU same operands → 2.
- Signed: DIV -7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIV 7/-2 → 0xFFFFFFFD; REM 7/-2 → 1.
- Divide by zero: DIVU 5/0 → ready after E0, result 0xFFFFFFFF; REM -5/0 → result 0xFFFFFFFB; busy never asserts.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Handshake: second start at E10 with different operands is ignored and the first result is unchanged; back-to-back start during the ready cycle is accepted and the next ready comes 33 edges later.
- Reset: resetn low at E15 → busy=0, ready=0, result=0 immediately (asynchronous); no ready pulse appears after release; a fresh DIVU 9/3 then yields 3.
